// File: rtl/hyper_debug_capture.sv
// hyper_debug_capture: circular probe capture with pre-trigger window and oldest-first stream readout.
// Optional per-sample timestamp is enabled by defining HYPER_DEBUG_CAPTURE_TIMESTAMP_EN.
module hyper_debug_capture #(
   parameter int DATA_W = 160,
   parameter int DEPTH  = 16,
   parameter int PRE    = 4,
   parameter int TS_W   = 16,
   localparam int ADDR_W = $clog2(DEPTH),
`ifdef HYPER_DEBUG_CAPTURE_TIMESTAMP_EN
   localparam int RD_W = TS_W + DATA_W
`else
   localparam int RD_W = DATA_W + 0 * TS_W
`endif
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              arm,
   input  logic              abort,
   input  logic              sample_en,
   input  logic [DATA_W-1:0] probe,
   input  logic              trigger,
   output logic              armed,
   output logic              triggered,
   output logic              done,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [RD_W-1:0]   rd_data,
   output logic              rd_last
);
   typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, READ} state_t;
   localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRE);
   localparam logic [ADDR_W-1:0] POST_N = ADDR_W'(DEPTH - PRE - 1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
   state_t              state;
   logic [ADDR_W-1:0]   wr_ptr, trig_ptr, rd_ptr, pre_cnt, post_cnt, rd_cnt;
   logic                rd_go;
   logic [RD_W-1:0]     mem [DEPTH];
   logic [RD_W-1:0]     wr_word;
   logic                cap, we, trig_ok, load;
`ifdef HYPER_DEBUG_CAPTURE_TIMESTAMP_EN
   logic [TS_W-1:0]     ts;
   // free-running timestamp stamped onto every stored sample
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) ts <= '0;
      else ts <= ts + TS_W'(1);
   assign wr_word = {ts, probe};
`else
   assign wr_word = probe;
`endif
   assign cap     = state == PREFILL || state == WAIT_TRIG || state == POST;
   assign we      = cap && sample_en && !abort;
   assign trig_ok = trigger && (state == WAIT_TRIG || (state == PREFILL && pre_cnt == PRE_A));
   assign load    = state == READ && rd_go && (!rd_valid || (rd_ready && !rd_last));
   // sample buffer write port; contents need no reset
   always_ff @(posedge sys_clk)
      if (we) mem[wr_ptr] <= wr_word;
   // capture/readout sequencer with registered status and stream outputs
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         trig_ptr  <= '0;
         rd_ptr    <= '0;
         pre_cnt   <= '0;
         post_cnt  <= '0;
         rd_cnt    <= '0;
         rd_go     <= 1'b0;
         armed     <= 1'b0;
         triggered <= 1'b0;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
      end else if (abort) begin
         state     <= IDLE;
         rd_go     <= 1'b0;
         armed     <= 1'b0;
         triggered <= 1'b0;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
      end else begin
         case (state)
            IDLE: if (arm) begin
               state   <= PREFILL;
               wr_ptr  <= '0;
               pre_cnt <= '0;
               armed   <= 1'b1;
            end
            PREFILL, WAIT_TRIG: if (sample_en) begin
               wr_ptr <= wr_ptr + ONE;
               if (trig_ok) begin
                  trig_ptr  <= wr_ptr;
                  post_cnt  <= POST_N;
                  armed     <= 1'b0;
                  triggered <= 1'b1;
                  if (POST_N == '0) begin
                     state  <= READ;
                     done   <= 1'b1;
                     rd_ptr <= wr_ptr - PRE_A;
                     rd_cnt <= '0;
                     rd_go  <= 1'b0;
                  end else begin
                     state <= POST;
                  end
               end else if (state == PREFILL && pre_cnt != PRE_A) begin
                  pre_cnt <= pre_cnt + ONE;
                  if (pre_cnt + ONE == PRE_A) state <= WAIT_TRIG;
               end else if (state == PREFILL) begin
                  state <= WAIT_TRIG;
               end
            end
            POST: if (sample_en) begin
               wr_ptr   <= wr_ptr + ONE;
               post_cnt <= post_cnt - ONE;
               if (post_cnt == ONE) begin
                  state  <= READ;
                  done   <= 1'b1;
                  rd_ptr <= trig_ptr - PRE_A;
                  rd_cnt <= '0;
                  rd_go  <= 1'b0;
               end
            end
            READ: begin
               rd_go <= 1'b1;
               if (load) begin
                  rd_data  <= mem[rd_ptr];
                  rd_valid <= 1'b1;
                  rd_last  <= rd_cnt == LAST_A;
                  rd_ptr   <= rd_ptr + ONE;
                  rd_cnt   <= rd_cnt + ONE;
               end else if (rd_valid && rd_ready) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
                  if (rd_last) begin
                     state     <= IDLE;
                     triggered <= 1'b0;
                     done      <= 1'b0;
                     rd_data   <= '0;
                     rd_go     <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hyper_debug_capture.sv
// tb_hyper_debug_capture: directed scenario bench for hyper_debug_capture (DEPTH=16, PRE=4, probe=sample index).
module tb_hyper_debug_capture;
   localparam int DATA_W = 160;
   localparam int DEPTH  = 16;
   localparam int PRE    = 4;
   localparam int TS_W   = 16;
`ifdef HYPER_DEBUG_CAPTURE_TIMESTAMP_EN
   localparam int RD_W = DATA_W + TS_W;
`else
   localparam int RD_W = DATA_W;
`endif
   logic              sys_clk = 1'b0;
   logic              sys_rst, arm, abort, sample_en, trigger, rd_ready;
   logic [DATA_W-1:0] probe;
   logic              armed, triggered, done, rd_valid, rd_last;
   logic [RD_W-1:0]   rd_data;
   int                checks = 0;
   int                passed = 0;
   logic [RD_W-1:0]   got [$];
   int                last_idx;
   bit                unstable, tmo;

   always #5 sys_clk = ~sys_clk;

   hyper_debug_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRE(PRE), .TS_W(TS_W)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .arm(arm), .abort(abort), .sample_en(sample_en),
      .probe(probe), .trigger(trigger), .armed(armed), .triggered(triggered), .done(done),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last));

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic feed(input int n, input bit en, input bit trg);
      probe = DATA_W'(n);
      sample_en = en;
      trigger = trg;
      step();
      sample_en = 1'b0;
      trigger = 1'b0;
   endtask

   task automatic start();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic capture(input int t1, input int t2, input int last_n);
      start();
      for (int n = 0; n <= last_n; n++) feed(n, 1'b1, n == t1 || n == t2);
   endtask

   task automatic drain(input bit toggle);
      logic [RD_W-1:0] pdata;
      bit plast, pstall;
      got.delete();
      last_idx = -1;
      unstable = 1'b0;
      tmo = 1'b1;
      pstall = 1'b0;
      pdata = '0;
      plast = 1'b0;
      for (int c = 0; c < 200 && tmo; c++) begin
         rd_ready = !toggle || (c % 2 == 0);
         if (pstall && (!rd_valid || rd_data !== pdata || rd_last !== plast)) unstable = 1'b1;
         if (rd_valid && rd_ready) begin
            got.push_back(rd_data);
            if (rd_last) begin
               last_idx = got.size() - 1;
               tmo = 1'b0;
            end
         end
         pstall = rd_valid && !rd_ready;
         pdata = rd_data;
         plast = rd_last;
         step();
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; arm = 1'b0; abort = 1'b0; sample_en = 1'b0; trigger = 1'b0; rd_ready = 1'b0; probe = '0;
      step();
      step();
      checks++;
      if ({armed, triggered, done, rd_valid, rd_last} !== 5'b0 || rd_data !== '0)
         $display("FAIL reset_outputs got status=%b data=%0h exp 0", {armed, triggered, done, rd_valid, rd_last}, rd_data);
      else passed++;
      sys_rst = 1'b0;
      step();
      start();
      feed(0, 1'b1, 1'b0);
      checks++;
      if (armed !== 1'b1) $display("FAIL armed_prefill got %b exp 1", armed); else passed++;
      #2 sys_rst = 1'b1;
      #1;
      checks++;
      if (armed !== 1'b0) $display("FAIL async_reset got armed=%b exp 0", armed); else passed++;
      sys_rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      capture(10, -1, 10);
      checks++;
      if ({armed, triggered, done} !== 3'b010) $display("FAIL trig_status got %b exp 010", {armed, triggered, done}); else passed++;
      for (int n = 11; n <= 21; n++) feed(n, 1'b1, 1'b0);
      checks++;
      if (done !== 1'b1 || rd_valid !== 1'b0) $display("FAIL read_entry got done=%b valid=%b exp 1/0", done, rd_valid); else passed++;
      step();
      checks++;
      if (rd_valid !== 1'b0) $display("FAIL latency1 got valid=%b exp 0", rd_valid); else passed++;
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data[DATA_W-1:0] !== DATA_W'(6))
         $display("FAIL latency2 got valid=%b data=%0h exp 1/6", rd_valid, rd_data[DATA_W-1:0]);
      else passed++;
      drain(1'b0);
      checks++;
      if (got.size() != 16 || last_idx != 15) $display("FAIL basic_count got %0d last=%0d exp 16/15", got.size(), last_idx); else passed++;
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i][DATA_W-1:0] !== DATA_W'(6 + i)) $display("FAIL basic_word%0d got %0h exp %0h", i, got[i][DATA_W-1:0], 6 + i); else passed++;
      end
      checks++;
      if ({triggered, done, rd_valid, rd_last} !== 4'b0) $display("FAIL basic_idle got %b exp 0000", {triggered, done, rd_valid, rd_last}); else passed++;
   endtask

   task automatic test_prefill_ignore();
      capture(2, 7, 2);
      checks++;
      if ({armed, triggered} !== 2'b10) $display("FAIL prefill_ignore got %b exp 10", {armed, triggered}); else passed++;
      for (int n = 3; n <= 18; n++) feed(n, 1'b1, n == 7);
      drain(1'b0);
      checks++;
      if (got.size() != 16 || last_idx != 15) $display("FAIL prefill_count got %0d last=%0d exp 16/15", got.size(), last_idx); else passed++;
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i][DATA_W-1:0] !== DATA_W'(3 + i)) $display("FAIL prefill_word%0d got %0h exp %0h", i, got[i][DATA_W-1:0], 3 + i); else passed++;
      end
   endtask

   task automatic test_stall();
      capture(10, -1, 21);
      drain(1'b1);
      checks++;
      if (unstable !== 1'b0) $display("FAIL stall_stable got unstable=%b exp 0", unstable); else passed++;
      checks++;
      if (got.size() != 16 || last_idx != 15) $display("FAIL stall_count got %0d last=%0d exp 16/15", got.size(), last_idx); else passed++;
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i][DATA_W-1:0] !== DATA_W'(6 + i)) $display("FAIL stall_word%0d got %0h exp %0h", i, got[i][DATA_W-1:0], 6 + i); else passed++;
      end
   endtask

   task automatic test_gap();
      capture(10, -1, 10);
      for (int n = 11; n <= 21; n++) begin
         feed(999, 1'b0, 1'b1);
         feed(n, 1'b1, 1'b0);
         if (n == 20) begin
            checks++;
            if (done !== 1'b0) $display("FAIL gap_early got done=%b exp 0", done); else passed++;
         end
      end
      checks++;
      if (done !== 1'b1) $display("FAIL gap_done got done=%b exp 1", done); else passed++;
      drain(1'b0);
      checks++;
      if (got.size() != 16 || last_idx != 15) $display("FAIL gap_count got %0d last=%0d exp 16/15", got.size(), last_idx); else passed++;
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i][DATA_W-1:0] !== DATA_W'(6 + i)) $display("FAIL gap_word%0d got %0h exp %0h", i, got[i][DATA_W-1:0], 6 + i); else passed++;
      end
   endtask

   task automatic test_boundaries();
      capture(4, -1, 15);
      drain(1'b0);
      checks++;
      if (got.size() != 16 || got[0][DATA_W-1:0] !== DATA_W'(0) || got[15][DATA_W-1:0] !== DATA_W'(15))
         $display("FAIL first_wait_trig got n=%0d first=%0h exp 16 words 0..15", got.size(), got.size() > 0 ? got[0][DATA_W-1:0] : '1);
      else passed++;
      capture(30, -1, 41);
      drain(1'b0);
      checks++;
      if (got.size() != 16) $display("FAIL wrap_count got %0d exp 16", got.size()); else passed++;
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i][DATA_W-1:0] !== DATA_W'(26 + i)) $display("FAIL wrap_word%0d got %0h exp %0h", i, got[i][DATA_W-1:0], 26 + i); else passed++;
      end
   endtask

   task automatic test_abort();
      capture(10, -1, 12);
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if ({armed, triggered, done, rd_valid, rd_last} !== 5'b0) $display("FAIL abort_post got %b exp 00000", {armed, triggered, done, rd_valid, rd_last}); else passed++;
      arm = 1'b1;
      abort = 1'b1;
      step();
      arm = 1'b0;
      abort = 1'b0;
      checks++;
      if ({armed, triggered, done} !== 3'b0) $display("FAIL arm_abort got %b exp 000", {armed, triggered, done}); else passed++;
      capture(-1, -1, 5);
      abort = 1'b1;
      feed(6, 1'b1, 1'b1);
      abort = 1'b0;
      checks++;
      if ({armed, triggered} !== 2'b0) $display("FAIL abort_trig got %b exp 00", {armed, triggered}); else passed++;
      capture(10, -1, 21);
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (rd_valid !== 1'b0 || done !== 1'b0 || rd_data !== '0) $display("FAIL abort_read got valid=%b done=%b data=%0h exp 0", rd_valid, done, rd_data); else passed++;
      capture(10, -1, 21);
      drain(1'b0);
      checks++;
      if (got.size() != 16 || last_idx != 15) $display("FAIL rearm_count got %0d last=%0d exp 16/15", got.size(), last_idx); else passed++;
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i][DATA_W-1:0] !== DATA_W'(6 + i)) $display("FAIL rearm_word%0d got %0h exp %0h", i, got[i][DATA_W-1:0], 6 + i); else passed++;
      end
   endtask

`ifdef HYPER_DEBUG_CAPTURE_TIMESTAMP_EN
   task automatic test_timestamp();
      logic [TS_W-1:0] a, b;
      capture(10, -1, 21);
      drain(1'b0);
      for (int i = 1; i < got.size(); i++) begin
         a = got[i-1][RD_W-1:DATA_W];
         b = got[i][RD_W-1:DATA_W];
         checks++;
         if (b - a !== TS_W'(1)) $display("FAIL ts_step%0d got %0h after %0h exp +1", i, b, a); else passed++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_prefill_ignore();
      test_stall();
      test_gap();
      test_boundaries();
      test_abort();
`ifdef HYPER_DEBUG_CAPTURE_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
